// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller:
// FSM states, MemRead/MemWrite encodings and the packed control-output bundle.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;
  localparam logic [1:0] MEM_HALF = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic hazard_detected;
    logic mem_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1,
    idex_write: 1'b0, exmem_write: 1'b0, memwb_write: 1'b0,
    hazard_detected: 1'b0, mem_busy: 1'b0};

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0,
    idex_write: 1'b0, exmem_write: 1'b0, memwb_write: 1'b0,
    hazard_detected: 1'b1, mem_busy: 1'b1};

  // Squashes both the IF/ID and ID/EX wrong-path instructions.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1,
    idex_write: 1'b1, exmem_write: 1'b1, memwb_write: 1'b1,
    hazard_detected: 1'b0, mem_busy: 1'b0};

  localparam ctrl_t CTRL_JUMP = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0,
    idex_write: 1'b1, exmem_write: 1'b1, memwb_write: 1'b1,
    hazard_detected: 1'b0, mem_busy: 1'b0};

  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1,
    idex_write: 1'b1, exmem_write: 1'b1, memwb_write: 1'b1,
    hazard_detected: 1'b1, mem_busy: 1'b0};

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0,
    idex_write: 1'b1, exmem_write: 1'b1, memwb_write: 1'b1,
    hazard_detected: 1'b0, mem_busy: 1'b0};

  function automatic logic is_mem_op(input logic [1:0] rd, input logic [1:0] wr);
    return (rd | wr) != MEM_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle and flush-event statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes and whole-pipeline freezes for multi-cycle memory.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [1:0]       ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic [1:0]       mem_mem_read,
  input  logic [1:0]       mem_mem_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             hazard_detected,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // The RUN cycle that detects the access is itself frozen, so WAIT only
  // needs to cover MEM_LAT-2 further cycles before the release cycle.
  localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  ctrl_t      ctrl;
  logic       mem_op;
  logic       freeze;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  always_comb begin
    mem_op   = is_mem_op(mem_mem_read, mem_mem_write);
    freeze   = ((state_q == RUN) && mem_op && (MEM_LAT > 1)) ||
               ((state_q == WAIT) && (wait_cnt_q != 4'd0));
    load_use = (ex_mem_read != MEM_NONE) && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_RUN;
    flush_inc  = 1'b0;
    if (reset) begin
      ctrl       = CTRL_RESET;
      state_d    = RUN;
      wait_cnt_d = 4'd0;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
      if (state_q == RUN) begin
        state_d    = WAIT;
        wait_cnt_d = WAIT_INIT;
      end else begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
    end else begin
      // Also the release cycle: the finished access must not re-trigger.
      state_d    = RUN;
      wait_cnt_d = 4'd0;
      if (ex_branch_taken) begin
        ctrl      = CTRL_BRANCH;
        flush_inc = 1'b1;
      end else if (id_jump) begin
        ctrl      = CTRL_JUMP;
        flush_inc = 1'b1;
      end else if (load_use) begin
        ctrl = CTRL_LOAD_USE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_write        = ctrl.pc_write;
  assign ifid_write      = ctrl.ifid_write;
  assign ifid_flush      = ctrl.ifid_flush;
  assign idex_bubble     = ctrl.idex_bubble;
  assign idex_write      = ctrl.idex_write;
  assign exmem_write     = ctrl.exmem_write;
  assign memwb_write     = ctrl.memwb_write;
  assign hazard_detected = ctrl.hazard_detected;
  assign mem_busy        = ctrl.mem_busy;

  assign stall_inc = !reset && !ctrl.pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Drives three differently parameterised hazard controllers with shared
// directed and random stimulus and compares them to a cycle-level model.
module tb_pipeline_hazard_ctrl;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{4, 3, 1};
  localparam int CW  [NDUT] = '{16, 4, 4};

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idRs, idRt, exRd;
  logic       idUsesRt, idJump, exBranchTaken;
  logic [1:0] exMemRead, memMemRead, memMemWrite;

  logic [8:0]  ctrlObs  [NDUT];
  logic [31:0] stallObs [NDUT];
  logic [31:0] flushObs [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    logic pcW, ifidW, ifidF, idexB, idexW, exmemW, memwbW, hazD, memB;
    logic [CW[g]-1:0] stallCnt, flushCnt;

    pipeline_hazard_ctrl #(.MEM_LAT(LAT[g]), .CNT_W(CW[g])) uDut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (idRs),
      .id_rt           (idRt),
      .id_uses_rt      (idUsesRt),
      .id_jump         (idJump),
      .ex_mem_read     (exMemRead),
      .ex_rd           (exRd),
      .ex_branch_taken (exBranchTaken),
      .mem_mem_read    (memMemRead),
      .mem_mem_write   (memMemWrite),
      .pc_write        (pcW),
      .ifid_write      (ifidW),
      .ifid_flush      (ifidF),
      .idex_bubble     (idexB),
      .idex_write      (idexW),
      .exmem_write     (exmemW),
      .memwb_write     (memwbW),
      .hazard_detected (hazD),
      .mem_busy        (memB),
      .stall_cycles    (stallCnt),
      .flush_count     (flushCnt)
    );

    assign ctrlObs[g]  = {pcW, ifidW, ifidF, idexB, idexW, exmemW, memwbW, hazD, memB};
    assign stallObs[g] = 32'(stallCnt);
    assign flushObs[g] = 32'(flushCnt);
  end

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: cycles already spent frozen on the current access.
  int   frozenCycles [NDUT];
  int   stallModel   [NDUT];
  int   flushModel   [NDUT];
  bit   modelValid = 0;
  logic [8:0] lastCtrl [NDUT];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int satInc(input int value, input int width);
    int cap = (1 << width) - 1;
    return (value + 1 > cap) ? cap : value + 1;
  endfunction

  // Evaluate one cycle after the inputs settle, then advance the model to the next edge.
  task automatic runCycle();
    logic [8:0] expCtrl;
    bit memOp, frozen, loadUse, incStall, incFlush;
    #1;
    memOp   = (memMemRead != 2'd0) || (memMemWrite != 2'd0);
    loadUse = (exMemRead != 2'd0) && (exRd != 5'd0) &&
              ((exRd == idRs) || (idUsesRt && (exRd == idRt)));
    for (int g = 0; g < NDUT; g++) begin
      if (modelValid) begin
        checkOutput($sformatf("stall%0d", g), stallObs[g], 32'(stallModel[g]));
        checkOutput($sformatf("flush%0d", g), flushObs[g], 32'(flushModel[g]));
      end
      incStall = 0;
      incFlush = 0;
      if (reset) begin
        expCtrl = 9'b001100000;
      end else begin
        if (frozenCycles[g] > 0) frozen = frozenCycles[g] < LAT[g] - 1;
        else                     frozen = memOp && (LAT[g] > 1);
        if (frozen) begin
          expCtrl  = 9'b000000011;
          incStall = 1;
          frozenCycles[g]++;
        end else begin
          frozenCycles[g] = 0;
          if (exBranchTaken) begin
            expCtrl  = 9'b111111100;
            incFlush = 1;
          end else if (idJump) begin
            expCtrl  = 9'b111011100;
            incFlush = 1;
          end else if (loadUse) begin
            expCtrl  = 9'b000111110;
            incStall = 1;
          end else begin
            expCtrl  = 9'b110011100;
          end
        end
      end
      checkOutput($sformatf("ctrl%0d", g), 32'(ctrlObs[g]), 32'(expCtrl));
      lastCtrl[g] = ctrlObs[g];
      if (reset) begin
        frozenCycles[g] = 0;
        stallModel[g]   = 0;
        flushModel[g]   = 0;
      end else begin
        if (incStall) stallModel[g] = satInc(stallModel[g], CW[g]);
        if (incFlush) flushModel[g] = satInc(flushModel[g], CW[g]);
      end
    end
    if (reset) modelValid = 1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic jump, input logic [1:0] exMr,
                               input logic [4:0] rd, input logic br, input logic [1:0] memR,
                               input logic [1:0] memW);
    reset         = rst;
    idRs          = rs;
    idRt          = rt;
    idUsesRt      = usesRt;
    idJump        = jump;
    exMemRead     = exMr;
    exRd          = rd;
    exBranchTaken = br;
    memMemRead    = memR;
    memMemWrite   = memW;
    runCycle();
  endtask

  task automatic idle();
    applyStimulus(0, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 0, 2'd0, 2'd0);
  endtask

  task automatic doReset();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 2'd0, 5'd0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    logic [7:0] busyPattern;
    logic [2:0] flushPattern;
    for (int g = 0; g < NDUT; g++) begin
      frozenCycles[g] = 0;
      stallModel[g]   = 0;
      flushModel[g]   = 0;
    end
    @(negedge clk);

    doReset();
    checkOutput("resetCtrl", 32'(lastCtrl[2]), 32'h060);
    idle();

    // Load-use: lw $8 in EX, add reading $8 in ID.
    doReset();
    applyStimulus(0, 5'd8, 5'd3, 1, 0, 2'b01, 5'd8, 0, 2'd0, 2'd0);
    checkOutput("loadUsePc", 32'(lastCtrl[2][8]), 32'd0);
    idle();
    checkOutput("loadUseStall", stallObs[2], 32'd1);

    // Load targeting $zero never stalls.
    applyStimulus(0, 5'd0, 5'd0, 1, 0, 2'b01, 5'd0, 0, 2'd0, 2'd0);
    checkOutput("zeroLoadPc", 32'(lastCtrl[2][8]), 32'd1);

    // Taken branch pulse.
    doReset();
    applyStimulus(0, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 1, 2'd0, 2'd0);
    checkOutput("branchCtrl", 32'(lastCtrl[2]), 32'h1fc);
    idle();
    checkOutput("branchFlushCnt", flushObs[2], 32'd1);

    // Back-to-back lw then sw held in MEM on the MEM_LAT=4 instance.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 0,
                    (i < 4) ? 2'b01 : 2'b00, (i < 4) ? 2'b00 : 2'b01);
      busyPattern[7-i] = lastCtrl[0][0];
    end
    checkOutput("freezePattern", 32'(busyPattern), 32'h0ee);
    idle();
    checkOutput("freezeStall", stallObs[0], 32'd6);

    // Branch during a MEM_LAT=3 freeze flushes only on the release cycle.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 1, 2'b10, 2'd0);
      flushPattern[2-i] = lastCtrl[1][6];
    end
    checkOutput("priorityFlush", 32'(flushPattern), 32'd1);

    // Reset in WAIT aborts the freeze.
    idle();
    applyStimulus(0, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 0, 2'b11, 2'd0);
    applyStimulus(1, 5'd1, 5'd2, 0, 0, 2'd0, 5'd0, 0, 2'b11, 2'd0);
    idle();
    checkOutput("abortBusy", 32'(lastCtrl[1][0]), 32'd0);
    checkOutput("abortStall", stallObs[1], 32'd0);

    // Saturation with 4-bit counters.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 5'd8, 5'd9, 0, 0, 2'b01, 5'd8, 0, 2'd0, 2'd0);
    end
    idle();
    checkOutput("saturate", stallObs[2], 32'd15);

    // Randomised traffic with small register ranges to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                    5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                    ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage MIPS pipeline. It detects load-use hazards in ID, flushes wrong-path instructions on taken branches and jumps, and freezes the whole pipeline while a multi-cycle data-memory access (lw/lh/lb/sw/sh/sb) completes in MEM. It drives the pipeline-register write enables and flushes, and feeds `hazard_detected` to the main decoder. Two saturating performance counters report stall cycles and flush events.

## Interface
- `MEM_LAT`, default 1: data-memory latency in cycles, 1 to 16. A value of 1 means a single-cycle memory, and the block never freezes.
- `CNT_W`, default 16: width of the performance counters.

- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt (R-type, sw/sh/sb, beq/bneq).
- `id_jump` in 1: Jump control signal decoded in ID.
- `ex_mem_read` in 2: MemRead of the instruction in EX. Nonzero means it is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_branch_taken` in 1: a branch resolved taken in EX this cycle.
- `mem_mem_read` in 2: MemRead of the instruction in MEM.
- `mem_mem_write` in 2: MemWrite of the instruction in MEM.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID write enable.
- `ifid_flush` out 1: IF/ID is loaded with a NOP.
- `idex_bubble` out 1: ID/EX is loaded with zeroed controls.
- `idex_write` out 1: ID/EX write enable.
- `exmem_write` out 1: EX/MEM write enable.
- `memwb_write` out 1: MEM/WB write enable.
- `hazard_detected` out 1: tells Control to hold its outputs.
- `mem_busy` out 1: a pipeline freeze for memory is active.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_write` = 0.
- `flush_count` out CNT_W: saturating count of flush events.

## Operation
Conditions are evaluated every cycle. The first matching condition in the list below wins.

1. **Reset** (`reset` = 1):
   - FSM goes to RUN, `wait_cnt` = 0, both counters = 0.
   - All write enables = 0, `ifid_flush` = 1, `idex_bubble` = 1.
   - `hazard_detected` = 0, `mem_busy` = 0.
2. **Freeze**. It applies in either case below:
   - state is RUN, (`mem_mem_read` | `mem_mem_write`) != 0, and `MEM_LAT` > 1; or
   - state is WAIT and `wait_cnt` != 0.
   
   While frozen, every write enable = 0, flushes = 0, `mem_busy` = 1 and `hazard_detected` = 1. All other hazards are ignored; the stages are held, so those hazards are re-evaluated after release.
3. **Taken branch** (`ex_branch_taken`): `ifid_flush` = 1, `idex_bubble` = 1, `pc_write` = 1. Two wrong-path instructions are squashed. `flush_count` += 1.
4. **Jump** (`id_jump`): `ifid_flush` = 1, `pc_write` = 1, all other enables = 1. `flush_count` += 1.
5. **Load-use**: applies when `ex_mem_read` != 0, `ex_rd` != 0, and (`ex_rd` == `id_rs` or (`id_uses_rt` and `ex_rd` == `id_rt`)).
   - `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1, `hazard_detected` = 1.
   - The stall lasts one cycle; MEM/WB forwarding covers the rest.
6. **Otherwise**: all write enables = 1, flushes = 0.

FSM states are RUN and WAIT:
- RUN to WAIT on the freeze condition, loading `wait_cnt` = `MEM_LAT` − 2.
- WAIT with `wait_cnt` != 0: stay frozen and decrement `wait_cnt`.
- WAIT with `wait_cnt` == 0: this is the release cycle. There is no freeze; rules 3 to 6 apply and the state returns to RUN.
- The access in MEM therefore completes on the release cycle without re-triggering. A memory op that follows back-to-back enters MEM one cycle later and triggers a new freeze.

Counters:
- `stall_cycles` increments on each non-reset cycle with `pc_write` = 0.
- Both counters stop at 2^CNT_W − 1 and do not wrap.
- `wait_cnt` is 4 bits wide.

## Timing
- The hazard outputs are combinational from the inputs and the current state, with zero-cycle latency.
- FSM state, `wait_cnt` and the counters are registered and update on the `clk` rising edge.
- Freeze length is exactly `MEM_LAT` − 1 cycles, starting in the first cycle the access is present in MEM.
- Counter outputs reflect events up to the previous edge.
- Reset asserted mid-freeze aborts the wait immediately. The next cycle is RUN with `wait_cnt` = 0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum `{RUN, WAIT}`;
  - MemRead/MemWrite encodings: 00 none, 01 word, 10 byte, 11 half;
  - the `REG_ZERO` constant.
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `count`), is instantiated twice.

## Test plan
- **Load-use.** EX holds lw with `ex_rd` = 8; ID holds add with `id_rs` = 8. Required: exactly one cycle with `pc_write` = 0 and `idex_bubble` = 1. `stall_cycles` = 1.
- **Load to $zero.** Load with `ex_rd` = 0 and `id_rs` = 0. Required: no stall.
- **Branch.** `ex_branch_taken` pulses for 1 cycle. Required: `ifid_flush` = 1 and `idex_bubble` = 1 for that cycle. `flush_count` = 1.
- **Memory freeze.** `MEM_LAT` = 4, sw held in MEM. Required: freeze for 3 cycles, release on the 4th. Back-to-back lw then sw gives 3 frozen, 1 release, 3 frozen.
- **Priority.** `MEM_LAT` = 3, freeze active while `ex_branch_taken` = 1. Required: no flush while frozen; the flush fires on the release cycle. Reset asserted during WAIT returns the block to RUN with counters = 0.
- **Saturation.** `CNT_W` = 4, 20 load-use stalls. Required: `stall_cycles` holds at 15.
